// File: rtl/theia_wb_mem_slave_pkg.sv
// theia_wb_mem_slave_pkg: bus width, FSM encodings and region tags for the THEIA memory slave
`ifndef WB_WIDTH
`define WB_WIDTH 32
`endif
package theia_wb_mem_slave_pkg;
  localparam int unsigned WB_W = `WB_WIDTH;
  localparam logic [1:0] MEMSL_IDLE = 2'd0;
  localparam logic [1:0] MEMSL_WRITE = 2'd1;
  localparam logic [1:0] MEMSL_READ_WAIT = 2'd2;
  localparam logic [1:0] MEMSL_ACK = 2'd3;
  localparam logic [1:0] TAG_INSTR = 2'b00;
  localparam logic [1:0] TAG_DATA = 2'b01;
  localparam logic [1:0] TAG_OUTPUT = 2'b10;
  localparam logic [1:0] TAG_CONFIG = 2'b11;
endpackage

// File: rtl/theia_mem_rd_latency.sv
// theia_mem_rd_latency: loadable down-counter, done marks the SRAM read-capture cycle
module theia_mem_rd_latency #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);
  logic [2:0] cnt;
  always_ff @(posedge clk)
    cnt <= rst ? 3'd0 : load ? 3'(LATENCY) : cnt - 3'(cnt != 3'd0);
  assign done = cnt == 3'd0;
endmodule

// File: rtl/theia_wb_mem_slave.sv
// theia_wb_mem_slave: Wishbone classic slave driving a single-port sync SRAM, tag-selected regions
// Optional range check with oAddrErr enabled by defining THEIA_MEM_ADDR_CHECK_EN.
module theia_wb_mem_slave
  import theia_wb_mem_slave_pkg::*;
#(
  parameter int unsigned WB_WIDTH = `WB_WIDTH,
  parameter int unsigned REGION_BITS = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic                   CYC_I,
  input  logic                   STB_I,
  input  logic                   WE_I,
  input  logic [WB_WIDTH-1:0]    ADR_I,
  input  logic [WB_WIDTH-1:0]    DAT_I,
  input  logic [1:0]             TGA_I,
  output logic                   ACK_O,
  output logic [WB_WIDTH-1:0]    DAT_O,
  output logic [REGION_BITS+1:0] oMemAddr,
  output logic                   oMemWe,
  output logic                   oMemRe,
  output logic [WB_WIDTH-1:0]    oMemWData,
  input  logic [WB_WIDTH-1:0]    iMemRData,
  output logic                   oBusy
`ifdef THEIA_MEM_ADDR_CHECK_EN
  ,output logic                  oAddrErr
`endif
);
  logic [1:0] state, next;
  logic accept, rd_done, rd_cap, err, err_q, re_q;
  assign accept = state == MEMSL_IDLE && CYC_I && STB_I;
  assign rd_cap = state == MEMSL_READ_WAIT && CYC_I && rd_done;
`ifdef THEIA_MEM_ADDR_CHECK_EN
  assign err = |(ADR_I >> REGION_BITS);
  always_ff @(posedge CLK_I)
    oAddrErr <= RST_I ? 1'b0 : oAddrErr | (accept && WE_I && err) | (rd_cap && err_q);
`else
  assign err = 1'b0;
`endif
  theia_mem_rd_latency #(.LATENCY(READ_LATENCY)) u_lat (
    .clk (CLK_I),
    .rst (RST_I),
    .load(accept && !WE_I),
    .done(rd_done)
  );
  always_comb
    next = state == MEMSL_IDLE ? (accept ? (WE_I ? MEMSL_WRITE : MEMSL_READ_WAIT) : MEMSL_IDLE) :
           state == MEMSL_READ_WAIT ? (!CYC_I ? MEMSL_IDLE : rd_done ? MEMSL_ACK : MEMSL_READ_WAIT) :
           MEMSL_IDLE;
  always_ff @(posedge CLK_I)
    if (RST_I) begin
      state <= MEMSL_IDLE;
      DAT_O <= '0;
      oMemAddr <= '0;
      oMemWData <= '0;
      err_q <= 1'b0;
      re_q <= 1'b0;
    end else begin
      state <= next;
      re_q <= accept && !WE_I && !err;
      if (accept) begin
        oMemAddr <= {TGA_I, ADR_I[REGION_BITS-1:0]};
        oMemWData <= DAT_I;
        err_q <= err;
      end
      // aborted reads never reach rd_cap, so stale SRAM data is dropped
      if (rd_cap) DAT_O <= err_q ? '0 : iMemRData;
    end
  assign oMemRe = re_q;
  assign oMemWe = state == MEMSL_WRITE && !err_q;
  assign ACK_O = state == MEMSL_WRITE || state == MEMSL_ACK;
  assign oBusy = state != MEMSL_IDLE;
endmodule

// File: tb/tb_theia_wb_mem_slave.sv
// tb_theia_wb_mem_slave: directed checks of three slaves (READ_LATENCY 1, 4, 3) sharing one bus
module tb_theia_wb_mem_slave;
  logic clk = 1'b0, rst, cyc, stb, we;
  logic [31:0] adr, dat;
  logic [1:0] tga;
  logic ack [3], re [3], wo [3], busy [3];
  logic [31:0] dout [3], wd [3], rd [3], pd [3];
  logic [11:0] ma [3];
  logic [2:0] pc [3];
`ifdef THEIA_MEM_ADDR_CHECK_EN
  logic aerr [3];
`endif
  logic [31:0] mem [4096];
  int checks = 0, errors = 0, acks;
  always #5 clk = ~clk;

  theia_wb_mem_slave #(.WB_WIDTH(32), .REGION_BITS(10), .READ_LATENCY(1)) d0 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr), .DAT_I(dat),
    .TGA_I(tga), .ACK_O(ack[0]), .DAT_O(dout[0]), .oMemAddr(ma[0]), .oMemWe(wo[0]),
    .oMemRe(re[0]), .oMemWData(wd[0]), .iMemRData(rd[0]), .oBusy(busy[0])
`ifdef THEIA_MEM_ADDR_CHECK_EN
    , .oAddrErr(aerr[0])
`endif
  );
  theia_wb_mem_slave #(.WB_WIDTH(32), .REGION_BITS(10), .READ_LATENCY(4)) d1 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr), .DAT_I(dat),
    .TGA_I(tga), .ACK_O(ack[1]), .DAT_O(dout[1]), .oMemAddr(ma[1]), .oMemWe(wo[1]),
    .oMemRe(re[1]), .oMemWData(wd[1]), .iMemRData(rd[1]), .oBusy(busy[1])
`ifdef THEIA_MEM_ADDR_CHECK_EN
    , .oAddrErr(aerr[1])
`endif
  );
  theia_wb_mem_slave #(.WB_WIDTH(32), .REGION_BITS(10), .READ_LATENCY(3)) d2 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr), .DAT_I(dat),
    .TGA_I(tga), .ACK_O(ack[2]), .DAT_O(dout[2]), .oMemAddr(ma[2]), .oMemWe(wo[2]),
    .oMemRe(re[2]), .oMemWData(wd[2]), .iMemRData(rd[2]), .oBusy(busy[2])
`ifdef THEIA_MEM_ADDR_CHECK_EN
    , .oAddrErr(aerr[2])
`endif
  );

  // SRAM model: data valid only in the single cycle READ_LATENCY after oMemRe
  always @(posedge clk) begin
    if (wo[0]) mem[ma[0]] <= wd[0];
    for (int i = 0; i < 3; i++)
      if (rst) pc[i] <= 3'd0;
      else if (re[i]) begin
        pc[i] <= (i == 0) ? 3'd1 : (i == 1) ? 3'd4 : 3'd3;
        pd[i] <= mem[ma[i]];
      end else if (pc[i] != 3'd0) pc[i] <= pc[i] - 3'd1;
  end
  always_comb
    for (int i = 0; i < 3; i++) rd[i] = (pc[i] == 3'd1) ? pd[i] : 32'hBAD0BAD0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_ack"}, 32'(ack[i]), 32'd0);
      chk({tag, "_busy"}, 32'(busy[i]), 32'd0);
      chk({tag, "_re"}, 32'(re[i]), 32'd0);
      chk({tag, "_we"}, 32'(wo[i]), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h5; dat = 32'h0; tga = 2'b00;
    tick; tick; tick;
    chk_idle("reset");
    for (int i = 0; i < 3; i++) begin
      chk("reset_dat", dout[i], 32'h0);
      chk("reset_addr", 32'(ma[i]), 32'h0);
      chk("reset_wdata", wd[i], 32'h0);
    end
    rst = 1'b0;
    #3;
    chk_idle("post_reset");
    cyc = 1'b0; stb = 1'b0;
    tick;
    chk_idle("post_reset2");
    // single write: tag 1, word 5
    cyc = 1'b1; stb = 1'b1; we = 1'b1; tga = 2'b01; adr = 32'h5; dat = 32'hDEADBEEF;
    tick;
    chk("wr_addr", 32'(ma[0]), 32'h405);
    chk("wr_we", 32'(wo[0]), 32'd1);
    chk("wr_ack", 32'(ack[0]), 32'd1);
    chk("wr_wdata", wd[0], 32'hDEADBEEF);
    chk("wr_re", 32'(re[0]), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    tick;
    chk_idle("wr_done");
    // read back same address
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) chk("rd_re_n1", 32'(re[i]), 32'd1);
    chk("rd_ack_n1", 32'(ack[0]), 32'd0);
    chk("rd_busy_n1", 32'(busy[0]), 32'd1);
    stb = 1'b0;
    tick;
    chk("rd_re_n2", 32'(re[0]), 32'd0);
    chk("rd_ack_n2", 32'(ack[0]), 32'd0);
    tick;
    chk("rd_l1_ack_n3", 32'(ack[0]), 32'd1);
    chk("rd_l1_dat_n3", dout[0], 32'hDEADBEEF);
    chk("rd_l4_ack_n3", 32'(ack[1]), 32'd0);
    tick;
    chk("rd_l1_ack_n4", 32'(ack[0]), 32'd0);
    chk("rd_l1_busy_n4", 32'(busy[0]), 32'd0);
    chk("rd_l3_ack_n4", 32'(ack[2]), 32'd0);
    tick;
    chk("rd_l3_ack_n5", 32'(ack[2]), 32'd1);
    chk("rd_l3_dat_n5", dout[2], 32'hDEADBEEF);
    chk("rd_l4_ack_n5", 32'(ack[1]), 32'd0);
    tick;
    chk("rd_l4_ack_n6", 32'(ack[1]), 32'd1);
    chk("rd_l4_dat_n6", dout[1], 32'hDEADBEEF);
    chk("rd_l1_hold_n6", dout[0], 32'hDEADBEEF);
    chk("rd_l3_ack_n6", 32'(ack[2]), 32'd0);
    tick;
    chk_idle("rd_done");
    cyc = 1'b0;
    // three back-to-back writes with STB held high
    cyc = 1'b1; stb = 1'b1; we = 1'b1; tga = 2'b10; adr = 32'h3FF; dat = 32'h12345678;
    acks = 0;
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (k == 5) stb = 1'b0;
      chk("b2b_ack", 32'(ack[0]), 32'(k % 2));
      acks += int'(ack[0]);
    end
    chk("b2b_count", 32'(acks), 32'd3);
    chk("b2b_addr", 32'(ma[0]), 32'hBFF);
    cyc = 1'b0; we = 1'b0;
    tick;
    // read aborted by CYC low at N+2: data in flight must not land in DAT_O
    cyc = 1'b1; stb = 1'b1;
    tick;
    stb = 1'b0;
    tick;
    chk("abort_busy_n2", 32'(busy[2]), 32'd1);
    cyc = 1'b0;
    tick;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        chk("abort_ack", 32'(ack[i]), 32'd0);
        chk("abort_busy", 32'(busy[i]), 32'd0);
        chk("abort_dat", dout[i], 32'hDEADBEEF);
      end
      tick;
    end
    // completed read of the second location
    cyc = 1'b1; stb = 1'b1;
    tick;
    stb = 1'b0;
    tick;
    tick;
    chk("rd2_ack", 32'(ack[0]), 32'd1);
    chk("rd2_dat", dout[0], 32'h12345678);
    cyc = 1'b0;
    tick; tick; tick; tick;
`ifndef THEIA_MEM_ADDR_CHECK_EN
    // upper address bits wrap within the region
    cyc = 1'b1; stb = 1'b1; we = 1'b1; tga = 2'b11; adr = 32'hFFFF_F805; dat = 32'h0BADF00D;
    tick;
    chk("wrap_addr", 32'(ma[0]), 32'hC05);
    chk("wrap_we", 32'(wo[0]), 32'd1);
    chk("wrap_ack", 32'(ack[0]), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick;
`else
    // out-of-range read: no strobe, ACK on schedule with zero data, sticky error
    cyc = 1'b1; stb = 1'b1; we = 1'b0; tga = 2'b00; adr = 32'h400;
    tick;
    chk("oor_re", 32'(re[0]), 32'd0);
    chk("oor_err_n1", 32'(aerr[0]), 32'd0);
    stb = 1'b0;
    tick;
    chk("oor_ack_n2", 32'(ack[0]), 32'd0);
    tick;
    chk("oor_ack_n3", 32'(ack[0]), 32'd1);
    chk("oor_dat_n3", dout[0], 32'h0);
    chk("oor_err_n3", 32'(aerr[0]), 32'd1);
    cyc = 1'b0;
    tick; tick; tick; tick;
    chk("oor_err_sticky", 32'(aerr[0]), 32'd1);
    chk("oor_l4_err", 32'(aerr[1]), 32'd1);
`endif
    // reset in the middle of a read drops it with no ACK
    cyc = 1'b1; stb = 1'b1; we = 1'b0; tga = 2'b01; adr = 32'h5;
    tick;
    stb = 1'b0;
    rst = 1'b1;
    tick;
    chk_idle("midrst");
    for (int i = 0; i < 3; i++) chk("midrst_dat", dout[i], 32'h0);
`ifdef THEIA_MEM_ADDR_CHECK_EN
    chk("midrst_err", 32'(aerr[0]), 32'd0);
`endif
    rst = 1'b0; cyc = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("midrst_noack", 32'(ack[1]), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/theia_wb_mem_slave.md
# theia_wb_mem_slave

Wishbone classic slave that serves the THEIA top-level master bus. It sits directly downstream of the core arbiter/mux: it consumes the arbitrated CYC/STB/WE/ADR/DAT/TGA outputs, drives a single-port synchronous SRAM, and returns ACK and read data into THEIA's ACK_I/DAT_I. The 2-bit address tag selects one of four equal memory regions, so cores address instruction, data and output spaces independently.

## Interface
- WB_WIDTH, `WB_WIDTH: data and address bus width.
- REGION_BITS, 10: word-address bits per tag region; 2^REGION_BITS words per region.
- READ_LATENCY, 1: SRAM read latency in cycles. Legal range 1..4.
- CLK_I  in  1  single clock; all logic on rising edge.
- RST_I  in  1  reset, synchronous, active-high.
- CYC_I  in  1  bus cycle from THEIA CYC_O (arbitrated request).
- STB_I  in  1  strobe from THEIA STB_O.
- WE_I  in  1  write enable from THEIA WE_O.
- ADR_I  in  WB_WIDTH  word address from THEIA ADR_O.
- DAT_I  in  WB_WIDTH  write data from THEIA DAT_O.
- TGA_I  in  2  region tag from THEIA TGA_O.
- ACK_O  out  1  transfer acknowledge to THEIA ACK_I.
- DAT_O  out  WB_WIDTH  read data to THEIA DAT_I.
- oMemAddr  out  REGION_BITS+2  SRAM address = {TGA, ADR_I[REGION_BITS-1:0]}.
- oMemWe  out  1  SRAM write strobe.
- oMemRe  out  1  SRAM read strobe.
- oMemWData  out  WB_WIDTH  SRAM write data.
- iMemRData  in  WB_WIDTH  SRAM read data, valid READ_LATENCY cycles after oMemRe.
- oBusy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, WRITE, READ_WAIT, ACK.
- IDLE: when CYC_I & STB_I sampled high, register ADR_I, DAT_I, TGA_I, WE_I; go WRITE if WE_I, else READ_WAIT (issuing oMemRe).
- WRITE: oMemWe=1, ACK_O=1 for exactly this cycle; next state IDLE.
- READ_WAIT: oMemRe high for first cycle only; a latency counter loads READ_LATENCY and decrements; at zero capture iMemRData into DAT_O, go ACK.
- ACK: ACK_O=1 one cycle, DAT_O holds captured data; next state IDLE.
- After every ACK the slave spends at least one cycle in IDLE; STB_I still high in that IDLE cycle starts a new transfer (Wishbone classic, no burst).
- CYC_I low in READ_WAIT: abort, return IDLE next cycle, no ACK; in-flight SRAM data discarded.
- CYC_I low in WRITE: write still completes (already committed), ACK still pulses.
- Address bits above REGION_BITS ignored (wrap within region) unless check enabled.
- DAT_O updated only on read capture; holds last read value otherwise.

## Timing
- Reset: state IDLE, ACK_O=0, DAT_O=0, oMemWe=0, oMemRe=0, oMemAddr=0, oMemWData=0, oBusy=0, counter=0.
- Write: request sampled cycle N; oMemWe and ACK_O in N+1. Throughput one write per 2 cycles.
- Read: request sampled N; oMemRe in N+1; iMemRData valid N+1+READ_LATENCY, captured that edge; ACK_O with DAT_O in N+2+READ_LATENCY.
- RST_I asserted in any state: outputs return to reset values the following cycle; pending transfer dropped, no ACK.
- ACK_O never high two consecutive cycles.

## Configuration
- THEIA_MEM_ADDR_CHECK_EN defined: any ADR_I bit above REGION_BITS-1 set marks request out-of-range; no SRAM strobe issued; ACK still returned on normal schedule (read returns DAT_O=0); extra output oAddrErr (1 bit, sticky, cleared only by RST_I) sets in the ACK cycle.
- Undefined: no range check, upper bits silently dropped, no oAddrErr port.

## Structure
- Shared definitions include: `WB_WIDTH, state encodings (MEMSL_IDLE..MEMSL_ACK), region tag constants (instruction, data, output, config).
- One sub-module: theia_mem_rd_latency, the loadable down-counter producing the read-capture strobe.

## Test plan
- Reset with CYC_I=STB_I=1 held: no ACK, all outputs 0 while RST_I high and first cycle after.
- Write TGA=2'b01, ADR=0x05, DAT=0xDEADBEEF -> oMemAddr=0x405, oMemWe and ACK_O one cycle at N+1.
- Read back same address, READ_LATENCY=1 -> oMemRe at N+1, ACK_O with DAT_O=0xDEADBEEF at N+3; repeat with READ_LATENCY=4 -> ACK at N+6.
- STB_I held high across 3 back-to-back writes -> exactly 3 ACK pulses, each separated by one idle cycle.
- Read issued, CYC_I dropped at N+2 (READ_LATENCY=3) -> no ACK, DAT_O unchanged, IDLE at N+3.
- With THEIA_MEM_ADDR_CHECK_EN, REGION_BITS=10, read ADR=0x400 -> no oMemRe, ACK at N+2+READ_LATENCY with DAT_O=0, oAddrErr=1 until reset.
